// File: rtl/instr_mem_pl.sv
// Handshaked instruction memory for the fetch stage: posedge synchronous array,
// configurable read latency, out-of-range error flag and a run-time loader port.
module instr_mem_pl #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 10,
    parameter int                 DEPTH     = 1024,
    parameter int                 LATENCY   = 1,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0,
    parameter string              INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] instr,
    output logic              rd_err,
    input  logic              rsp_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              accept;
    logic              rd_in_range;
    logic              ld_in_range;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic              err_q;
    logic [DATA_W-1:0] data_out;
    logic              err_out;

    // The loader owns the cycle: a write strobe blocks acceptance of a fetch.
    assign rd_ready    = !ld_en && ((state_reg == IDLE) || ((state_reg == RESP) && rsp_ready));
    assign accept      = rd_req && rd_ready;
    assign rd_in_range = (32'(rd_addr) < DEPTH);
    assign ld_in_range = (32'(ld_addr) < DEPTH);

    // Read-before-write: a read sampled on the same edge as a write sees old data.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) begin
            mem[ld_addr[IDX_W-1:0]] <= ld_data;
        end
        if (accept && rd_in_range) begin
            ram_q <= mem[rd_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= !rd_in_range;
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign data_out = ram_q;
            assign err_out  = err_q;
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe_data [LATENCY-1];
            logic              pipe_err  [LATENCY-1];

            for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        pipe_data[gi] <= ram_q;
                        pipe_err[gi]  <= err_q;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        pipe_data[gi] <= pipe_data[gi-1];
                        pipe_err[gi]  <= pipe_err[gi-1];
                    end
                end
            end

            assign data_out = pipe_data[LATENCY-2];
            assign err_out  = pipe_err[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (accept) begin
                        if (LATENCY > 1) begin
                            state_next = WAIT;
                            cnt_next   = CNT_LOAD;
                        end else begin
                            state_next = RESP;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are gated by rd_valid so reset and idle present zeros without resetting the RAM path.
    assign rd_valid = (state_reg == RESP);
    assign rd_err   = rd_valid && err_out;
    assign instr    = !rd_valid ? '0 : (err_out ? NOP_INSTR : data_out);

endmodule

// File: tb/tb_instr_mem_pl.sv
// Bench for instr_mem_pl: three instances (latency 1, 3, 4) driven by directed and
// random fetch/load traffic, checked against an array-based memory model.
module tb_instr_mem_pl;

    localparam int              NI    = 3;
    localparam int              DW    = 16;
    localparam int              AW    = 10;
    localparam int              DEPTH = 768;
    localparam logic [DW-1:0]   NOP   = 16'hA5A5;
    localparam int              LATS [NI] = '{1, 3, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]         rd_req, rd_ready, rd_valid, rd_err, rsp_ready, ld_en;
    logic [NI-1:0][AW-1:0] rd_addr, ld_addr;
    logic [NI-1:0][DW-1:0] instr, ld_data;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            instr_mem_pl #(
                .DATA_W   (DW),
                .ADDR_W   (AW),
                .DEPTH    (DEPTH),
                .LATENCY  (LATS[gi]),
                .NOP_INSTR(NOP),
                .INIT_FILE("")
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .rd_req   (rd_req[gi]),
                .rd_addr  (rd_addr[gi]),
                .rd_ready (rd_ready[gi]),
                .rd_valid (rd_valid[gi]),
                .instr    (instr[gi]),
                .rd_err   (rd_err[gi]),
                .rsp_ready(rsp_ready[gi]),
                .ld_en    (ld_en[gi]),
                .ld_addr  (ld_addr[gi]),
                .ld_data  (ld_data[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem   [NI][1024];
    logic [DW-1:0] pend_data [NI];
    logic          pend_err  [NI];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Loader strobes are single-cycle: every edge retires them.
    task automatic tick();
        @(posedge clk);
        #1;
        ld_en = '0;
    endtask

    task automatic model_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (int'(a) < DEPTH) ref_mem[k][a] = d;
    endtask

    task automatic load(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en[k]   = 1'b1;
        ld_addr[k] = a;
        ld_data[k] = d;
        model_write(k, a, d);
        #1 chk("ready_during_ld", k, 32'(rd_ready[k]), 32'd0);
        tick();
    endtask

    // Issue a fetch, optionally overwrite the same word right after acceptance,
    // then follow it through the wait cycles to the response.
    task automatic issue(input int k, input logic [AW-1:0] a, input bit clobber);
        int lat;
        lat = LATS[k];
        rd_req[k]    = 1'b1;
        rd_addr[k]   = a;
        rsp_ready[k] = 1'b1;
        #1 chk("ready_req", k, 32'(rd_ready[k]), 32'd1);
        if (int'(a) >= DEPTH) begin
            pend_err[k]  = 1'b1;
            pend_data[k] = NOP;
        end else begin
            pend_err[k]  = 1'b0;
            pend_data[k] = ref_mem[k][a];
        end
        tick();
        rd_req[k]    = 1'b0;
        rd_addr[k]   = AW'($urandom);
        rsp_ready[k] = 1'b0;
        if (clobber) begin
            ld_en[k]   = 1'b1;
            ld_addr[k] = a;
            ld_data[k] = ~pend_data[k];
            model_write(k, a, ~pend_data[k]);
        end
        for (int i = 0; i < lat - 1; i++) begin
            chk("valid_wait", k, 32'(rd_valid[k]), 32'd0);
            chk("ready_wait", k, 32'(rd_ready[k]), 32'd0);
            tick();
        end
        chk("valid_resp", k, 32'(rd_valid[k]), 32'd1);
        chk("instr", k, 32'(instr[k]), 32'(pend_data[k]));
        chk("err", k, 32'(rd_err[k]), 32'(pend_err[k]));
    endtask

    task automatic hold(input int k, input int n);
        rsp_ready[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("valid_hold", k, 32'(rd_valid[k]), 32'd1);
            chk("instr_hold", k, 32'(instr[k]), 32'(pend_data[k]));
            chk("err_hold", k, 32'(rd_err[k]), 32'(pend_err[k]));
            chk("ready_hold", k, 32'(rd_ready[k]), 32'd0);
        end
    endtask

    task automatic consume(input int k);
        rsp_ready[k] = 1'b1;
        #1 chk("ready_resp", k, 32'(rd_ready[k]), 32'(!ld_en[k]));
        tick();
        chk("valid_done", k, 32'(rd_valid[k]), 32'd0);
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        bit            in_resp;
        bit            last_clob;
        bit            clob;
        logic [AW-1:0] a;

        rd_req    = '0;
        rd_addr   = '0;
        rsp_ready = '0;
        ld_en     = '0;
        ld_addr   = '0;
        ld_data   = '0;
        rst_n     = 1'b0;

        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", k, 32'(rd_valid[k]), 32'd0);
            chk("rst_err", k, 32'(rd_err[k]), 32'd0);
            chk("rst_instr", k, 32'(instr[k]), 32'd0);
            chk("rst_ready", k, 32'(rd_ready[k]), 32'd1);
        end
        #3 rst_n = 1'b1;
        tick();

        // Load then read at latency 1, and the same for the longer latencies.
        load(0, 10'd5, 16'h1234);
        issue(0, 10'd5, 1'b0);
        consume(0);
        load(1, 10'd9, 16'h3939);
        issue(1, 10'd9, 1'b0);
        consume(1);
        load(2, 10'd7, 16'h4C4C);
        issue(2, 10'd7, 1'b0);
        consume(2);

        // Long stall followed by a back-to-back fetch.
        load(0, 10'd6, 16'hBEEF);
        load(0, 10'd4, 16'h0404);
        issue(0, 10'd4, 1'b0);
        hold(0, 5);
        issue(0, 10'd6, 1'b0);
        consume(0);

        // Out-of-range read, and a dropped out-of-range write.
        issue(0, 10'd800, 1'b0);
        hold(0, 1);
        consume(0);
        load(0, 10'd900, 16'h9999);
        issue(0, 10'd900, 1'b0);
        consume(0);

        // Write and read requested together: write wins, read follows with new data.
        ld_en[0]     = 1'b1;
        ld_addr[0]   = 10'd10;
        ld_data[0]   = 16'h7E57;
        model_write(0, 10'd10, 16'h7E57);
        rd_req[0]    = 1'b1;
        rd_addr[0]   = 10'd10;
        rsp_ready[0] = 1'b1;
        #1 chk("ready_prio", 0, 32'(rd_ready[0]), 32'd0);
        tick();
        chk("valid_prio", 0, 32'(rd_valid[0]), 32'd0);
        issue(0, 10'd10, 1'b0);
        consume(0);

        // Write to the in-flight word returns old data; the next read sees the new data.
        load(1, 10'd11, 16'h1111);
        issue(1, 10'd11, 1'b1);
        consume(1);
        issue(1, 10'd11, 1'b0);
        consume(1);

        // Reset with one instance mid-response and another mid-wait.
        load(0, 10'd12, 16'hC0DE);
        issue(0, 10'd12, 1'b0);
        rd_req[1]    = 1'b1;
        rd_addr[1]   = 10'd11;
        rsp_ready[1] = 1'b1;
        tick();
        rd_req[1] = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 32'(rd_valid[k]), 32'd0);
            chk("arst_err", k, 32'(rd_err[k]), 32'd0);
            chk("arst_instr", k, 32'(instr[k]), 32'd0);
            chk("arst_ready", k, 32'(rd_ready[k]), 32'd1);
        end
        tick();
        #2 rst_n = 1'b1;
        rsp_ready = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("aborted_valid", 1, 32'(rd_valid[1]), 32'd0);
            chk("aborted_valid", 0, 32'(rd_valid[0]), 32'd0);
        end
        chk("ready_after_rst", 1, 32'(rd_ready[1]), 32'd1);

        // Random traffic: stalls, back-to-back fetches, loads and in-flight overwrites.
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 64; w++) begin
                load(k, AW'(w), DW'($urandom));
            end
            in_resp   = 1'b0;
            last_clob = 1'b0;
            for (int it = 0; it < 30; it++) begin
                if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(DEPTH, 1023));
                else a = AW'($urandom_range(0, 63));
                clob = ($urandom_range(0, 3) == 0);
                if (!in_resp) begin
                    if ($urandom_range(0, 2) == 0) load(k, AW'($urandom_range(0, 63)), DW'($urandom));
                    issue(k, a, clob);
                    in_resp   = 1'b1;
                    last_clob = clob;
                end else if (!last_clob && ($urandom_range(0, 1) == 1)) begin
                    issue(k, a, clob);
                    last_clob = clob;
                end else begin
                    hold(k, int'($urandom_range(0, 3)));
                    consume(k);
                    in_resp   = 1'b0;
                    last_clob = 1'b0;
                end
            end
            if (in_resp) consume(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
